// File: rtl/bank_req_queue_if.sv
// Bank request queue bus interface.
// Groups the two read-request sources, the CDB writeback port and the
// register-file bank command port. The queue uses the slave modport; the
// requesting side (operand collectors, CDB, or a testbench) uses master.
interface bank_req_queue_if #(
    parameter int ROW_W  = 3,
    parameter int OCID_W = 3,
    parameter int DATA_W = 256
);
    // Source-1 read request
    logic              push1_valid;
    logic [ROW_W-1:0]  push1_row;
    logic [OCID_W-1:0] push1_ocid;

    // Source-2 read request
    logic              push2_valid;
    logic [ROW_W-1:0]  push2_row;
    logic [OCID_W-1:0] push2_ocid;

    // Space for a full dual push is available
    logic              push_ready;

    // CDB writeback request
    logic              wr_valid;
    logic [ROW_W-1:0]  wr_row;
    logic [DATA_W-1:0] wr_data;

    // Register-file bank command
    logic [ROW_W-1:0]  rf_addr;
    logic              rf_wr;
    logic [DATA_W-1:0] rf_wdata;

    // Read issue tag
    logic              rd_issue;
    logic [OCID_W-1:0] rd_ocid;

    modport master (
        output push1_valid, push1_row, push1_ocid,
        output push2_valid, push2_row, push2_ocid,
        output wr_valid, wr_row, wr_data,
        input  push_ready,
        input  rf_addr, rf_wr, rf_wdata,
        input  rd_issue, rd_ocid
    );

    modport slave (
        input  push1_valid, push1_row, push1_ocid,
        input  push2_valid, push2_row, push2_ocid,
        input  wr_valid, wr_row, wr_data,
        output push_ready,
        output rf_addr, rf_wr, rf_wdata,
        output rd_issue, rd_ocid
    );
endinterface

// File: rtl/bank_req_queue.sv
// Register-file bank request queue.
// Two read-request sources feed a circular FIFO of {ocid,row} entries. Each
// cycle the bank either performs a CDB writeback (which always wins) or
// issues the oldest queued read. Pointers carry one extra wrap bit so that
// full and empty are distinguishable and occupancy is a plain subtraction.
// Optional feature macro: REQ_BYPASS_EN -- when defined, a push1 request
// arriving at an empty, idle queue is issued to the bank in the same cycle
// instead of being stored.
module bank_req_queue #(
    parameter int DEPTH  = 8,
    parameter int ROW_W  = 3,
    parameter int OCID_W = 3,
    parameter int DATA_W = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    bank_req_queue_if.slave        bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int ENT_W = OCID_W + ROW_W;

    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [PTR_W-1:0] TWO_P   = PTR_W'(2);

    // Entry storage; deliberately not reset, pointers define validity
    logic [ENT_W-1:0]  mem [DEPTH];

    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  rp;
    logic [PTR_W-1:0]  wp_next;
    logic [PTR_W-1:0]  wp_plus1;
    logic [PTR_W-1:0]  occ;
    logic [PTR_W-1:0]  free_slots;

    logic              push_ready_int;
    logic              any_push;
    logic              accept;
    logic              drop;
    logic              bypass;
    logic              pop;

    logic              we_a;
    logic              we_b;
    logic [ENT_W-1:0]  data_a;
    logic [ENT_W-1:0]  data_b;
    logic [ENT_W-1:0]  entry1;
    logic [ENT_W-1:0]  entry2;
    logic [ENT_W-1:0]  head;
    logic [ROW_W-1:0]  head_row;
    logic [OCID_W-1:0] head_ocid;

    assign entry1 = {bus.push1_ocid, bus.push1_row};
    assign entry2 = {bus.push2_ocid, bus.push2_row};

    // Occupancy comes straight from the registered pointers, so it (and every
    // flag derived from it) clears the instant reset is applied.
    assign occ        = wp - rp;
    assign free_slots = DEPTH_P - occ;
    assign wp_plus1   = wp + ONE_P;

    assign count        = occ;
    assign empty        = (occ == '0);
    assign full         = (occ == DEPTH_P);

    // Conservative readiness: always room for a dual push, ignoring any pop
    // that happens in the same cycle.
    assign push_ready_int = (free_slots >= TWO_P);
    assign bus.push_ready = push_ready_int;

    // A push is all-or-nothing: either every valid source is taken or the
    // whole request is dropped and flagged.
    assign any_push = bus.push1_valid | bus.push2_valid;
    assign accept   = any_push & push_ready_int;
    assign drop     = any_push & ~push_ready_int;

    // Writebacks own the bank, so the head only leaves on a non-write cycle.
    assign pop = ~bus.wr_valid & ~empty;

    assign head      = mem[rp[IDX_W-1:0]];
    assign head_row  = head[ROW_W-1:0];
    assign head_ocid = head[ENT_W-1:ROW_W];

`ifdef REQ_BYPASS_EN
    assign bypass = empty & ~bus.wr_valid & bus.push1_valid & push_ready_int & ~rst;
`else
    assign bypass = 1'b0;
`endif

    // Write-slot planning: decide which entries land at wp and wp+1 and how
    // far the write pointer advances.
    always_comb begin
        we_a    = 1'b0;
        we_b    = 1'b0;
        data_a  = entry1;
        data_b  = entry2;
        wp_next = wp;
        if (accept) begin
            if (bypass) begin
                if (bus.push2_valid) begin
                    we_a    = 1'b1;
                    data_a  = entry2;
                    wp_next = wp_plus1;
                end
            end else if (bus.push1_valid && bus.push2_valid) begin
                we_a    = 1'b1;
                we_b    = 1'b1;
                data_a  = entry1;
                data_b  = entry2;
                wp_next = wp + TWO_P;
            end else if (bus.push1_valid) begin
                we_a    = 1'b1;
                data_a  = entry1;
                wp_next = wp_plus1;
            end else begin
                we_a    = 1'b1;
                data_a  = entry2;
                wp_next = wp_plus1;
            end
        end
    end

    // Entry storage writes at the planned slots
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[wp[IDX_W-1:0]] <= data_a;
        end
        if (we_b) begin
            mem[wp_plus1[IDX_W-1:0]] <= data_b;
        end
    end

    // Pointer and sticky overflow state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp           <= '0;
            rp           <= '0;
            overflow_err <= 1'b0;
        end else begin
            wp <= wp_next;
            if (pop) begin
                rp <= rp + ONE_P;
            end
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Bank command selection: writeback, then queued read, then bypass read;
    // idle drives zeros so the bank never sees X.
    always_comb begin
        bus.rf_wr    = bus.wr_valid;
        bus.rf_addr  = '0;
        bus.rd_issue = 1'b0;
        bus.rd_ocid  = '0;
        if (bus.wr_valid) begin
            bus.rf_addr = bus.wr_row;
        end else if (!empty && !rst) begin
            bus.rd_issue = 1'b1;
            bus.rf_addr  = head_row;
            bus.rd_ocid  = head_ocid;
        end else if (bypass) begin
            bus.rd_issue = 1'b1;
            bus.rf_addr  = bus.push1_row;
            bus.rd_ocid  = bus.push1_ocid;
        end
    end

    assign bus.rf_wdata = DATA_W'(bus.wr_data);

endmodule
